// File: rtl/id_ex_pipe_reg.sv
//------------------------------------------------------------------------------
// Module   : id_ex_pipe_reg
// Purpose  : ID/EX pipeline register and branch-stall arbiter. Captures the
//            forwarded operands and decoded control into EX, turns a branch
//            stall request into a single EX bubble while ID is held, honours
//            EX back-pressure and flush, and tracks the delay-slot flag that
//            is fed back to ID.
//            Optional: define ID_EX_PERF_CNT_EN to build the saturating
//            bubble/hold performance counters (otherwise tied to zero).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_pipe_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_inst_i,
  input  logic [7:0]  id_aluop_i,
  input  logic [2:0]  id_alusel_i,
  input  logic [31:0] id_rdata1_i,
  input  logic [31:0] id_rdata2_i,
  input  logic        id_we_i,
  input  logic [4:0]  id_waddr_i,
  input  logic [31:0] id_link_addr_i,
  input  logic        id_next_in_delayslot_i,
  input  logic        branch_stall_i,
  input  logic        ex_stall_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_inst_o,
  output logic [7:0]  ex_aluop_o,
  output logic [2:0]  ex_alusel_o,
  output logic [31:0] ex_rdata1_o,
  output logic [31:0] ex_rdata2_o,
  output logic        ex_we_o,
  output logic [4:0]  ex_waddr_o,
  output logic [31:0] ex_link_addr_o,
  output logic        ex_in_delayslot_o,
  output logic        id_in_delayslot_o,
  output logic        id_stall_o,
  output logic [31:0] bubble_cnt_o,
  output logic [31:0] hold_cnt_o
);

  // Per-cycle action, priority FLUSH > HOLD > BUBBLE > ADVANCE.
  logic w_flush;
  logic w_hold;
  logic w_bubble;
  logic w_advance;
  logic w_we_load;

  assign w_flush   = flush_i;
  assign w_hold    = ~flush_i & ex_stall_i;
  assign w_bubble  = ~flush_i & ~ex_stall_i & branch_stall_i;
  assign w_advance = ~flush_i & ~ex_stall_i & ~branch_stall_i;

  // A write is only real for a valid instruction targeting a non-zero register,
  // so the hazard unit never sees a live write to r0 or from an empty slot.
  assign w_we_load = id_valid_i & id_we_i & (id_waddr_i != 5'd0);

  assign id_stall_o = ~flush_i & (ex_stall_i | branch_stall_i);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [7:0]  r_aluop;
  logic [2:0]  r_alusel;
  logic [31:0] r_rdata1;
  logic [31:0] r_rdata2;
  logic        r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_link_addr;
  logic        r_ex_in_ds;
  logic        r_id_in_ds;

  // EX-stage field register: cleared on flush/bubble, loaded on advance, held otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_pc        <= 32'd0;
      r_inst      <= 32'd0;
      r_aluop     <= 8'd0;
      r_alusel    <= 3'd0;
      r_rdata1    <= 32'd0;
      r_rdata2    <= 32'd0;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_link_addr <= 32'd0;
      r_ex_in_ds  <= 1'b0;
    end else if (w_flush || w_bubble) begin
      r_valid     <= 1'b0;
      r_pc        <= 32'd0;
      r_inst      <= 32'd0;
      r_aluop     <= 8'd0;
      r_alusel    <= 3'd0;
      r_rdata1    <= 32'd0;
      r_rdata2    <= 32'd0;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_link_addr <= 32'd0;
      r_ex_in_ds  <= 1'b0;
    end else if (w_advance) begin
      r_valid     <= id_valid_i;
      r_pc        <= id_pc_i;
      r_inst      <= id_inst_i;
      r_aluop     <= id_aluop_i;
      r_alusel    <= id_alusel_i;
      r_rdata1    <= id_rdata1_i;
      r_rdata2    <= id_rdata2_i;
      r_we        <= w_we_load;
      r_waddr     <= id_waddr_i;
      r_link_addr <= id_link_addr_i;
      r_ex_in_ds  <= r_id_in_ds;
    end
  end

  // Delay-slot flag fed back to ID: set when a branch/jump leaves ID, held across stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id_in_ds <= 1'b0;
    end else if (w_flush) begin
      r_id_in_ds <= 1'b0;
    end else if (w_advance) begin
      r_id_in_ds <= id_valid_i & id_next_in_delayslot_i;
    end
  end

  assign ex_valid_o        = r_valid;
  assign ex_pc_o           = r_pc;
  assign ex_inst_o         = r_inst;
  assign ex_aluop_o        = r_aluop;
  assign ex_alusel_o       = r_alusel;
  assign ex_rdata1_o       = r_rdata1;
  assign ex_rdata2_o       = r_rdata2;
  assign ex_we_o           = r_we;
  assign ex_waddr_o        = r_waddr;
  assign ex_link_addr_o    = r_link_addr;
  assign ex_in_delayslot_o = r_ex_in_ds;
  assign id_in_delayslot_o = r_id_in_ds;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_bubble_cnt;
  logic [31:0] r_hold_cnt;

  // Saturating bubble/hold counters; only reset clears them, flush does not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bubble_cnt <= 32'd0;
      r_hold_cnt   <= 32'd0;
    end else begin
      if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (w_hold && (r_hold_cnt != c_CNT_MAX)) begin
        r_hold_cnt <= r_hold_cnt + 32'd1;
      end
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
  assign hold_cnt_o   = r_hold_cnt;
`else
  assign bubble_cnt_o = 32'd0;
  assign hold_cnt_o   = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_id_ex_pipe_reg
// Purpose  : Self-checking bench for id_ex_pipe_reg: directed scenarios and
//            randomized traffic compared against a behavioural model.
//            Honours ID_EX_PERF_CNT_EN for the expected counter values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_pipe_reg;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_inst_i;
  logic [7:0]  id_aluop_i;
  logic [2:0]  id_alusel_i;
  logic [31:0] id_rdata1_i;
  logic [31:0] id_rdata2_i;
  logic        id_we_i;
  logic [4:0]  id_waddr_i;
  logic [31:0] id_link_addr_i;
  logic        id_next_in_delayslot_i;
  logic        branch_stall_i;
  logic        ex_stall_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_inst_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_rdata1_o;
  logic [31:0] ex_rdata2_o;
  logic        ex_we_o;
  logic [4:0]  ex_waddr_o;
  logic [31:0] ex_link_addr_o;
  logic        ex_in_delayslot_o;
  logic        id_in_delayslot_o;
  logic        id_stall_o;
  logic [31:0] bubble_cnt_o;
  logic [31:0] hold_cnt_o;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .id_valid_i             (id_valid_i),
    .id_pc_i                (id_pc_i),
    .id_inst_i              (id_inst_i),
    .id_aluop_i             (id_aluop_i),
    .id_alusel_i            (id_alusel_i),
    .id_rdata1_i            (id_rdata1_i),
    .id_rdata2_i            (id_rdata2_i),
    .id_we_i                (id_we_i),
    .id_waddr_i             (id_waddr_i),
    .id_link_addr_i         (id_link_addr_i),
    .id_next_in_delayslot_i (id_next_in_delayslot_i),
    .branch_stall_i         (branch_stall_i),
    .ex_stall_i             (ex_stall_i),
    .flush_i                (flush_i),
    .ex_valid_o             (ex_valid_o),
    .ex_pc_o                (ex_pc_o),
    .ex_inst_o              (ex_inst_o),
    .ex_aluop_o             (ex_aluop_o),
    .ex_alusel_o            (ex_alusel_o),
    .ex_rdata1_o            (ex_rdata1_o),
    .ex_rdata2_o            (ex_rdata2_o),
    .ex_we_o                (ex_we_o),
    .ex_waddr_o             (ex_waddr_o),
    .ex_link_addr_o         (ex_link_addr_o),
    .ex_in_delayslot_o      (ex_in_delayslot_o),
    .id_in_delayslot_o      (id_in_delayslot_o),
    .id_stall_o             (id_stall_o),
    .bubble_cnt_o           (bubble_cnt_o),
    .hold_cnt_o             (hold_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what EX should contain after the next edge.
  logic        m_valid;
  logic [31:0] m_pc, m_inst, m_r1, m_r2, m_link;
  logic [7:0]  m_aluop;
  logic [2:0]  m_alusel;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic        m_ex_ds, m_id_ds;
  longint      m_bub, m_hold;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_inst = 0; m_r1 = 0; m_r2 = 0; m_link = 0;
    m_aluop = 0; m_alusel = 0; m_we = 0; m_waddr = 0;
    m_ex_ds = 0; m_id_ds = 0; m_bub = 0; m_hold = 0;
  endtask

  task automatic model_clear_ex();
    m_valid = 0; m_pc = 0; m_inst = 0; m_r1 = 0; m_r2 = 0; m_link = 0;
    m_aluop = 0; m_alusel = 0; m_we = 0; m_waddr = 0; m_ex_ds = 0;
  endtask

  // Decide what this cycle does from the current inputs and apply it to the model.
  task automatic model_step();
    if (flush_i) begin
      model_clear_ex();
      m_id_ds = 0;
    end else if (ex_stall_i) begin
      if (m_hold < 64'hFFFF_FFFF) m_hold++;
    end else if (branch_stall_i) begin
      model_clear_ex();
      if (m_bub < 64'hFFFF_FFFF) m_bub++;
    end else begin
      m_valid  = id_valid_i;
      m_pc     = id_pc_i;
      m_inst   = id_inst_i;
      m_aluop  = id_aluop_i;
      m_alusel = id_alusel_i;
      m_r1     = id_rdata1_i;
      m_r2     = id_rdata2_i;
      m_link   = id_link_addr_i;
      m_waddr  = id_waddr_i;
      m_we     = id_valid_i && id_we_i && (id_waddr_i != 0);
      m_ex_ds  = m_id_ds;
      m_id_ds  = id_valid_i && id_next_in_delayslot_i;
    end
  endtask

  function automatic logic [31:0] exp_cnt(input longint n);
    return PERF ? n[31:0] : 32'd0;
  endfunction

  function automatic logic exp_stall();
    return !flush_i && (ex_stall_i || branch_stall_i);
  endfunction

  task automatic compare_all();
    check_value("ex_valid",  {31'd0, ex_valid_o}, {31'd0, m_valid});
    check_value("ex_pc",     ex_pc_o, m_pc);
    check_value("ex_inst",   ex_inst_o, m_inst);
    check_value("ex_aluop",  {24'd0, ex_aluop_o}, {24'd0, m_aluop});
    check_value("ex_alusel", {29'd0, ex_alusel_o}, {29'd0, m_alusel});
    check_value("ex_rdata1", ex_rdata1_o, m_r1);
    check_value("ex_rdata2", ex_rdata2_o, m_r2);
    check_value("ex_we",     {31'd0, ex_we_o}, {31'd0, m_we});
    check_value("ex_waddr",  {27'd0, ex_waddr_o}, {27'd0, m_waddr});
    check_value("ex_link",   ex_link_addr_o, m_link);
    check_value("ex_in_ds",  {31'd0, ex_in_delayslot_o}, {31'd0, m_ex_ds});
    check_value("id_in_ds",  {31'd0, id_in_delayslot_o}, {31'd0, m_id_ds});
    check_value("bubble_cnt", bubble_cnt_o, exp_cnt(m_bub));
    check_value("hold_cnt",   hold_cnt_o, exp_cnt(m_hold));
  endtask

  // One clock: inputs are already applied (at posedge+1).
  task automatic cycle();
    #1;
    check_value("id_stall", {31'd0, id_stall_o}, {31'd0, exp_stall()});
    model_step();
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    id_valid_i = 0; id_pc_i = 0; id_inst_i = 0; id_aluop_i = 0; id_alusel_i = 0;
    id_rdata1_i = 0; id_rdata2_i = 0; id_we_i = 0; id_waddr_i = 0;
    id_link_addr_i = 0; id_next_in_delayslot_i = 0;
    branch_stall_i = 0; ex_stall_i = 0; flush_i = 0;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [31:0] inst, input logic [7:0] aluop,
                          input logic [31:0] r1, input logic [31:0] r2, input logic we,
                          input logic [4:0] waddr, input logic nds);
    id_valid_i = 1; id_pc_i = pc; id_inst_i = inst; id_aluop_i = aluop; id_alusel_i = 3'd1;
    id_rdata1_i = r1; id_rdata2_i = r2; id_we_i = we; id_waddr_i = waddr;
    id_link_addr_i = pc + 32'd8; id_next_in_delayslot_i = nds;
  endtask

  task automatic rand_id();
    id_valid_i = ($urandom_range(0, 3) != 0);
    id_pc_i = $urandom; id_inst_i = $urandom;
    id_aluop_i = 8'($urandom); id_alusel_i = 3'($urandom);
    id_rdata1_i = $urandom; id_rdata2_i = $urandom;
    id_we_i = 1'($urandom); id_waddr_i = 5'($urandom_range(0, 31));
    id_link_addr_i = $urandom; id_next_in_delayslot_i = 1'($urandom);
  endtask

  initial begin
    set_idle();
    rst_i = 1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    compare_all();
    check_value("rst_id_stall", {31'd0, id_stall_o}, 32'd0);
    rst_i = 0;

    // ADDU r3 advance
    drive_id(32'h0000_0100, 32'h0022_1821, 8'h21, 32'd5, 32'd7, 1'b1, 5'd3, 1'b0);
    cycle();
    check_value("addu_pc", ex_pc_o, 32'h100);
    check_value("addu_waddr", {27'd0, ex_waddr_o}, 32'd3);
    check_value("addu_we", {31'd0, ex_we_o}, 32'd1);
    check_value("addu_r1", ex_rdata1_o, 32'd5);
    check_value("addu_r2", ex_rdata2_o, 32'd7);
    check_value("addu_valid", {31'd0, ex_valid_o}, 32'd1);

    // BEQ waits one bubble for its operand, then advances
    drive_id(32'h0000_0104, 32'h1062_0004, 8'h51, 32'd9, 32'd9, 1'b0, 5'd0, 1'b1);
    branch_stall_i = 1;
    cycle();
    check_value("bub_valid", {31'd0, ex_valid_o}, 32'd0);
    check_value("bub_we", {31'd0, ex_we_o}, 32'd0);
    branch_stall_i = 0;
    cycle();
    check_value("beq_pc", ex_pc_o, 32'h104);
    check_value("beq_id_ds", {31'd0, id_in_delayslot_o}, 32'd1);
    check_value("beq_bubcnt", bubble_cnt_o, PERF ? 32'd1 : 32'd0);

    // Delay-slot instruction enters EX
    drive_id(32'h0000_0108, 32'h0043_2021, 8'h21, 32'd1, 32'd2, 1'b1, 5'd4, 1'b0);
    cycle();
    check_value("slot_ex_ds", {31'd0, ex_in_delayslot_o}, 32'd1);
    check_value("slot_id_ds", {31'd0, id_in_delayslot_o}, 32'd0);

    // Three HOLD cycles with changing ID inputs
    ex_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle();
      check_value("hold_pc", ex_pc_o, 32'h108);
    end
    check_value("hold_cnt3", hold_cnt_o, PERF ? 32'd3 : 32'd0);
    ex_stall_i = 0;

    // Flush beats stall and bubble; set a delay-slot flag first
    drive_id(32'h0000_0200, 32'h1000_0003, 8'h51, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    cycle();
    drive_id(32'h0000_0204, 32'h0000_0000, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    cycle();
    flush_i = 1; ex_stall_i = 1; branch_stall_i = 1;
    cycle();
    check_value("flush_valid", {31'd0, ex_valid_o}, 32'd0);
    check_value("flush_ds", {30'd0, ex_in_delayslot_o, id_in_delayslot_o}, 32'd0);
    flush_i = 0; ex_stall_i = 0; branch_stall_i = 0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_id();
      ex_stall_i     = ($urandom_range(0, 4) == 0);
      branch_stall_i = ($urandom_range(0, 4) == 0);
      flush_i        = ($urandom_range(0, 14) == 0);
      cycle();
    end

    // Asynchronous reset in the middle of a HOLD
    set_idle();
    drive_id(32'h0000_0300, 32'h0123_4567, 8'h21, 32'd11, 32'd12, 1'b1, 5'd7, 1'b1);
    cycle();
    ex_stall_i = 1;
    cycle();
    cycle();
    #2;
    rst_i = 1;
    model_reset();
    #1;
    compare_all();
    check_value("arst_pc", ex_pc_o, 32'd0);
    check_value("arst_stall", {31'd0, id_stall_o}, {31'd0, exp_stall()});
    @(posedge clk_i);
    #1;
    compare_all();
    rst_i = 0;
    ex_stall_i = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
